spi_slave_tx_rx: RTL and testbench
==================================

Name: spi_slave_tx_rx

Overview:
- SPI responder (slave) for one external SPI master; the counterpart of the team's SPI master transmitter/receiver.
- Oversamples sck/cs/mosi in the system clock domain and shifts 8-bit frames in both directions.
- Supports all four cpol/cpha modes and MSB- or LSB-first order.
- Presents a valid/ready TX byte buffer and a valid/ack RX byte register to the register-bank wrapper.

Parameters:
- sync_d, 2, number of synchronizer flops on spi_sck, spi_cs and spi_mosi (2 or more).

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous reset, active-low
- cpol  input  1  sck idle level
- cpha  input  1  0: sample on leading edge; 1: sample on trailing edge
- msb_lsb  input  1  1: MSB first; 0: LSB first
- tx_data  input  8  byte to transmit
- tx_vld  input  1  tx_data valid
- tx_rdy  output  1  TX buffer empty, can accept a byte
- rx_data  output  8  last received byte
- rx_vld  output  1  rx_data holds an unread byte
- rx_ack  input  1  consumer read rx_data
- rx_ovr  output  1  sticky overrun flag (see Optional Feature)
- ovr_clr  input  1  clears rx_ovr
- spi_sck  input  1  SPI clock from master
- spi_cs  input  1  SPI chip select, active-low
- spi_mosi  input  1  master-out data
- spi_miso  output  1  slave-out data
- spi_miso_oe  output  1  miso output enable (tri-state control)

Behaviour:
- Reset (rstn=0, asynchronous):
  - State IDLE, bit_c=0.
  - tx_rdy=1, rx_vld=0, rx_data=8'h00, rx_ovr=0.
  - spi_miso=0, spi_miso_oe=0.
  - Synchronizers reset to sck=cpol-independent 0, cs=1, mosi=0.
- Synchronization: sck, cs and mosi each pass through sync_d flops. sck_n = synced_sck ^ cpol.
  - Leading edge: sck_n 0->1.
  - Trailing edge: sck_n 1->0.
  - Edge detection uses the previous registered value.
- Clock ratio: correct operation requires f_clk >= 8 x f_sck. Below that ratio, behaviour is undefined.
- TX buffer:
  - A handshake occurs when tx_vld && tx_rdy.
  - On handshake: tx_buf<=tx_data, tx_rdy<=0 on the next cycle.
- Byte load into the shift register (shreg):
  - Occurs at cs assertion (IDLE->ACTIVE) and after the 8th sample within ACTIVE.
  - If tx_rdy=0: shreg<=tx_buf and tx_rdy<=1.
  - Otherwise (underrun): shreg<=8'hFF.
- Load and handshake in the same cycle: the load takes the old tx_buf state (empty -> 8'hFF); the new byte stays buffered for the next frame.
- FSM IDLE:
  - spi_miso_oe=0.
  - synced cs 1->0: go to ACTIVE, bit_c<=0, load shreg, spi_miso_oe<=1.
  - If cpha=0: spi_miso is driven with the first bit (shreg[7] or shreg[0], per msb_lsb) in the same cycle as the load.
- FSM ACTIVE:
  - cpha=0: sample mosi on the leading edge; shift out the next bit on the trailing edge.
  - cpha=1: shift out on the leading edge; sample on the trailing edge.
  - Sample: shreg shifts mosi in (MSB-first: {shreg[6:0],mosi}; LSB-first: {mosi,shreg[7:1]}), bit_c<=bit_c+1.
  - On the 8th sample (bit_c==7):
    - rx_data<=assembled byte, rx_vld<=1, bit_c<=0, next byte load.
    - For cpha=0, the new first bit goes onto miso on the same trailing edge that would shift.
- RX latency: rx_vld rises exactly sync_d+2 clk cycles after the final sampling pin edge.
- rx_ack: rx_vld<=0 next cycle. Byte completion in the same cycle as rx_ack wins: rx_vld stays 1 with the new data.
- Overrun: a byte completes while rx_vld=1 and rx_ack=0. rx_data is overwritten.
- cs deasserted (synced 0->1) in ACTIVE:
  - Return to IDLE, spi_miso_oe<=0, bit_c<=0.
  - A partial byte is discarded: no rx_vld, rx_data unchanged.
  - tx_buf is not consumed again.
- sck edges while IDLE are ignored.
- cpol, cpha and msb_lsb must be static while cs is asserted.

Optional Feature:
- Macro: SPI_SLV_OVR_EN.
- Defined:
  - rx_ovr is set on the overrun condition and stays set until ovr_clr=1.
  - Set and clear in the same cycle: set wins.
- Undefined: rx_ovr is tied to 0 and ovr_clr is ignored. Data overwrite behaviour is unchanged.

Test Plan:
- Mode 0, MSB first, clk = 16 x sck; tx byte 8'hA5 loaded before cs falls; master sends 8'h3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; rx_vld rises sync_d+2 clk after the 8th rising sck; tx_rdy=1 after cs falls.
- Mode 3 (cpol=1, cpha=1), LSB first; tx byte 8'h81; master sends 8'h01 -> miso bits 1,0,0,0,0,0,0,1; rx_data=8'h01.
- Two back-to-back bytes under one cs: 8'h11 preloaded, 8'h22 handshaked mid-frame -> miso sends 8'h11 then 8'h22; rx_vld asserted twice with the master's two bytes; rx_ack between them clears rx_vld.
- Underrun: no TX handshake before cs falls -> miso shifts 8'hFF; tx_rdy stays 1.
- cs raised after 4 sck pulses -> no rx_vld, rx_data keeps its previous value, spi_miso_oe=0; the next full frame receives correctly from bit 0.
- With SPI_SLV_OVR_EN: two bytes received without rx_ack -> rx_data = second byte, rx_ovr=1; ovr_clr pulse -> rx_ovr=0. Without the macro, rx_ovr stays 0. rstn pulled low mid-frame clears all outputs to their reset values immediately.

Source files
------------

// File: rtl/spi_slave_tx_rx.sv
// spi_slave_tx_rx: SPI responder for a single external master.
// sck/cs/mosi are oversampled in the clk domain through sync_d flops. The
// block shifts 8-bit frames in both directions in any cpol/cpha mode, with
// MSB- or LSB-first order.
//
// Ports
//   clk, rstn            system clock; asynchronous active-low reset
//   cpol, cpha, msb_lsb  SPI mode and bit order (static while cs is low)
//   tx_data/tx_vld/tx_rdy    one-byte TX buffer with a valid/ready handshake
//   rx_data/rx_vld/rx_ack    last received byte; valid until acknowledged
//   rx_ovr, ovr_clr      sticky overrun flag and its clear
//   spi_sck/spi_cs/spi_mosi  SPI pins from the master
//   spi_miso/spi_miso_oe     SPI data out and its tri-state enable
//
// Optional feature: define SPI_SLV_OVR_EN to enable the sticky rx_ovr flag.
// Without it, rx_ovr is tied low and ovr_clr is ignored.
module spi_slave_tx_rx #(
  parameter int sync_d = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       msb_lsb,
  input  logic [7:0] tx_data,
  input  logic       tx_vld,
  output logic       tx_rdy,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  input  logic       rx_ack,
  output logic       rx_ovr,
  input  logic       ovr_clr,
  input  logic       spi_sck,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe
);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t r_state, w_state_nxt;

  logic [sync_d-1:0] r_sck_s, r_cs_s, r_mosi_s;
  logic       r_sckn_q, r_cs_q;
  logic       r_lead, r_trail, r_cs_fall, r_cs_rise, r_mosi;
  logic [7:0] r_shreg, r_tx_buf;
  logic [2:0] r_bit_c;
  logic       w_sckn, w_sample, w_shift, w_done, w_start, w_end, w_load, w_ovr;
  logic [7:0] w_load_byte, w_rx_byte;

  // Synchronizers, previous-value registers, and registered pin events.
  // The event register adds one cycle, so a completed byte shows up
  // sync_d+2 cycles after the pin edge.
  assign w_sckn = r_sck_s[sync_d-1] ^ cpol;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sck_s   <= '0;
      r_cs_s    <= '1;
      r_mosi_s  <= '0;
      r_sckn_q  <= 1'b0;
      r_cs_q    <= 1'b1;
      r_lead    <= 1'b0;
      r_trail   <= 1'b0;
      r_cs_fall <= 1'b0;
      r_cs_rise <= 1'b0;
      r_mosi    <= 1'b0;
    end else begin
      r_sck_s   <= {r_sck_s[sync_d-2:0], spi_sck};
      r_cs_s    <= {r_cs_s[sync_d-2:0], spi_cs};
      r_mosi_s  <= {r_mosi_s[sync_d-2:0], spi_mosi};
      r_sckn_q  <= w_sckn;
      r_cs_q    <= r_cs_s[sync_d-1];
      r_lead    <= w_sckn & ~r_sckn_q;
      r_trail   <= ~w_sckn & r_sckn_q;
      r_cs_fall <= r_cs_q & ~r_cs_s[sync_d-1];
      r_cs_rise <= ~r_cs_q & r_cs_s[sync_d-1];
      r_mosi    <= r_mosi_s[sync_d-1];
    end
  end

  // A cs release overrides any sck event that arrives in the same cycle.
  assign w_start  = (r_state == IDLE) & r_cs_fall;
  assign w_end    = (r_state == ACTIVE) & r_cs_rise;
  assign w_sample = (r_state == ACTIVE) & ~r_cs_rise & (cpha ? r_trail : r_lead);
  assign w_shift  = (r_state == ACTIVE) & ~r_cs_rise & (cpha ? r_lead : r_trail);
  assign w_done   = w_sample & (r_bit_c == 3'd7);
  assign w_load   = w_start | w_done;

  // Underrun sends all ones. A handshake in the same cycle as a load is not
  // seen here; that byte waits in the buffer for the next frame.
  assign w_load_byte = tx_rdy ? 8'hFF : r_tx_buf;
  assign w_rx_byte   = msb_lsb ? {r_shreg[6:0], r_mosi} : {r_mosi, r_shreg[7:1]};
  assign w_ovr       = w_done & rx_vld & ~rx_ack;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_cs_fall) w_state_nxt = ACTIVE;
      ACTIVE:  if (r_cs_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shreg     <= 8'h00;
      r_bit_c     <= 3'd0;
      r_tx_buf    <= 8'h00;
      tx_rdy      <= 1'b1;
      rx_data     <= 8'h00;
      rx_vld      <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      // Handshake and load never coincide with tx_rdy=0, so they cannot conflict.
      if (tx_vld && tx_rdy) begin
        r_tx_buf <= tx_data;
        tx_rdy   <= 1'b0;
      end else if (w_load && !tx_rdy) begin
        tx_rdy   <= 1'b1;
      end

      if (w_load)        r_shreg <= w_load_byte;
      else if (w_sample) r_shreg <= w_rx_byte;

      if (w_start || w_end || w_done) r_bit_c <= 3'd0;
      else if (w_sample)              r_bit_c <= r_bit_c + 3'd1;

      // With cpha=0 the first bit must be on miso before the first leading
      // edge. On later bytes, the trailing-edge shift presents the new
      // first bit.
      if (w_start && !cpha) spi_miso <= msb_lsb ? w_load_byte[7] : w_load_byte[0];
      else if (w_shift)     spi_miso <= msb_lsb ? r_shreg[7] : r_shreg[0];
      else if (w_end)       spi_miso <= 1'b0;

      if (w_start)    spi_miso_oe <= 1'b1;
      else if (w_end) spi_miso_oe <= 1'b0;

      if (w_done) begin
        rx_data <= w_rx_byte;
        rx_vld  <= 1'b1;
      end else if (rx_ack) begin
        rx_vld  <= 1'b0;
      end
    end
  end

`ifdef SPI_SLV_OVR_EN
  // Set has priority over clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        rx_ovr <= 1'b0;
    else if (w_ovr)   rx_ovr <= 1'b1;
    else if (ovr_clr) rx_ovr <= 1'b0;
  end
`else
  logic w_unused_ovr;
  assign w_unused_ovr = w_ovr | ovr_clr;
  assign rx_ovr       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_tx_rx.sv
// tb_spi_slave_tx_rx: directed bench for spi_slave_tx_rx. It acts as the SPI
// master at clk = 16 x sck and checks the responses against hand-computed
// bytes.
module tb_spi_slave_tx_rx;
  localparam int SYNC_D = 2;
  localparam int H      = 8;   // sck half period in clk cycles

  logic       clk = 1'b0, rstn = 1'b0;
  logic       cpol = 1'b0, cpha = 1'b0, msb_lsb = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_vld = 1'b0, rx_ack = 1'b0, ovr_clr = 1'b0;
  logic       spi_sck = 1'b0, spi_cs = 1'b1, spi_mosi = 1'b0;
  logic       tx_rdy, rx_vld, rx_ovr, spi_miso, spi_miso_oe;
  logic [7:0] rx_data, mi;
  int         n_cmp = 0, n_err = 0;

`ifdef SPI_SLV_OVR_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  spi_slave_tx_rx #(.sync_d(SYNC_D)) dut (
    .clk(clk), .rstn(rstn), .cpol(cpol), .cpha(cpha), .msb_lsb(msb_lsb),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .rx_data(rx_data), .rx_vld(rx_vld), .rx_ack(rx_ack),
    .rx_ovr(rx_ovr), .ovr_clr(ovr_clr),
    .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hwait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    int t = 0;
    while (!tx_rdy && t < 200) begin hwait(1); t++; end
    chk("push_rdy", 8'(tx_rdy), 8'h01);
    tx_data = d; tx_vld = 1'b1;
    hwait(1);
    tx_vld = 1'b0;
  endtask

  task automatic ack;
    rx_ack = 1'b1; hwait(1); rx_ack = 1'b0;
  endtask

  // After the final sampling edge, optionally check the exact rx_vld latency.
  task automatic fin_wait(input bit lat);
    if (lat) begin
      hwait(SYNC_D + 1); chk("lat_lo", 8'(rx_vld), 8'h00);
      hwait(1);          chk("lat_hi", 8'(rx_vld), 8'h01);
      hwait(H - SYNC_D - 2);
    end else hwait(H);
  endtask

  // Master side of nb bits. mi collects miso at the master's sampling edge.
  task automatic xfer(input logic [7:0] mo, output logic [7:0] mi_o,
                      input bit lat, input int nb);
    int b;
    mi_o = 8'h00;
    for (int i = 0; i < nb; i++) begin
      b = msb_lsb ? 7 - i : i;
      if (!cpha) begin
        spi_mosi = mo[b]; hwait(H);
        spi_sck = ~cpol; mi_o[b] = spi_miso;
        fin_wait(lat && i == nb - 1);
        spi_sck = cpol;
      end else begin
        hwait(H);
        spi_sck = ~cpol; spi_mosi = mo[b]; hwait(H);
        spi_sck = cpol; mi_o[b] = spi_miso;
        fin_wait(lat && i == nb - 1);
      end
    end
    hwait(H);
  endtask

  task automatic cs_lo; spi_cs = 1'b0; hwait(H); endtask
  task automatic cs_hi; spi_cs = 1'b1; hwait(H); endtask

  task automatic set_mode(input logic pol, input logic pha, input logic msb);
    cpol = pol; cpha = pha; msb_lsb = msb; spi_sck = pol; hwait(2 * H);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    hwait(3);
    chk("rst_tx_rdy", 8'(tx_rdy), 8'h01);
    chk("rst_rx_vld", 8'(rx_vld), 8'h00);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_ovr", 8'(rx_ovr), 8'h00);
    chk("rst_miso", 8'(spi_miso), 8'h00);
    chk("rst_oe", 8'(spi_miso_oe), 8'h00);
    rstn = 1'b1; hwait(2 * H);

    // Mode 0, MSB first.
    push(8'hA5);
    chk("m0_rdy_lo", 8'(tx_rdy), 8'h00);
    cs_lo;
    chk("m0_oe", 8'(spi_miso_oe), 8'h01);
    chk("m0_rdy_hi", 8'(tx_rdy), 8'h01);
    xfer(8'h3C, mi, 1'b1, 8);
    chk("m0_miso", mi, 8'hA5);
    chk("m0_rx", rx_data, 8'h3C);
    ack;
    chk("m0_ack", 8'(rx_vld), 8'h00);
    cs_hi;
    chk("m0_oe_off", 8'(spi_miso_oe), 8'h00);

    // Mode 3, LSB first.
    set_mode(1'b1, 1'b1, 1'b0);
    push(8'h81);
    cs_lo;
    xfer(8'h01, mi, 1'b0, 8);
    chk("m3_miso", mi, 8'h81);
    chk("m3_rx", rx_data, 8'h01);
    chk("m3_vld", 8'(rx_vld), 8'h01);
    ack; cs_hi;

    // Back-to-back: 11 preloaded, 22 pushed during the first byte.
    set_mode(1'b0, 1'b0, 1'b1);
    push(8'h11);
    cs_lo;
    fork
      xfer(8'h5A, mi, 1'b0, 8);
      begin hwait(20); push(8'h22); end
    join
    chk("b2b_miso0", mi, 8'h11);
    chk("b2b_rx0", rx_data, 8'h5A);
    chk("b2b_vld0", 8'(rx_vld), 8'h01);
    chk("b2b_rdy", 8'(tx_rdy), 8'h01);
    ack;
    chk("b2b_ack", 8'(rx_vld), 8'h00);
    xfer(8'hC3, mi, 1'b0, 8);
    chk("b2b_miso1", mi, 8'h22);
    chk("b2b_rx1", rx_data, 8'hC3);
    chk("b2b_vld1", 8'(rx_vld), 8'h01);
    ack; cs_hi;

    // Underrun: nothing buffered, so the slave sends FF.
    cs_lo;
    xfer(8'h96, mi, 1'b0, 8);
    chk("und_miso", mi, 8'hFF);
    chk("und_rx", rx_data, 8'h96);
    chk("und_rdy", 8'(tx_rdy), 8'h01);
    ack; cs_hi;

    // Aborted frame after 4 bits, then a clean full frame.
    cs_lo;
    xfer(8'hF0, mi, 1'b0, 4);
    cs_hi;
    chk("abt_vld", 8'(rx_vld), 8'h00);
    chk("abt_rx", rx_data, 8'h96);
    chk("abt_oe", 8'(spi_miso_oe), 8'h00);
    push(8'h5C);
    cs_lo;
    xfer(8'hE7, mi, 1'b0, 8);
    chk("abt_miso", mi, 8'h5C);
    chk("abt_rx2", rx_data, 8'hE7);
    ack; cs_hi;

    // Overrun: two bytes without an ack.
    cs_lo;
    xfer(8'h12, mi, 1'b0, 8);
    xfer(8'h34, mi, 1'b0, 8);
    chk("ovr_rx", rx_data, 8'h34);
    chk("ovr_vld", 8'(rx_vld), 8'h01);
    chk("ovr_flag", 8'(rx_ovr), 8'(EXP_OVR));
    ovr_clr = 1'b1; hwait(1); ovr_clr = 1'b0; hwait(1);
    chk("ovr_clr", 8'(rx_ovr), 8'h00);

    // Reset in the middle of a frame, while rx_data and rx_vld are still set.
    push(8'hAA);
    xfer(8'h77, mi, 1'b0, 3);
    rstn = 1'b0; #1;
    chk("mrst_rdy", 8'(tx_rdy), 8'h01);
    chk("mrst_vld", 8'(rx_vld), 8'h00);
    chk("mrst_rx", rx_data, 8'h00);
    chk("mrst_oe", 8'(spi_miso_oe), 8'h00);
    chk("mrst_miso", 8'(spi_miso), 8'h00);
    chk("mrst_ovr", 8'(rx_ovr), 8'h00);
    spi_cs = 1'b1; hwait(2); rstn = 1'b1; hwait(H);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
